// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one single-port memory between i_cache (port 0) and d_cache (port 1).
// Each grant runs an optional writeback, then an optional fill, and ends with a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADD_WIDTH   = 12,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  c0_ren,
  input  logic                  c0_wen,
  input  logic [ADD_WIDTH-1:0]  c0_rd_address,
  input  logic [ADD_WIDTH-1:0]  c0_wr_address,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  output logic [DATA_WIDTH-1:0] c0_rdata,
  output logic                  c0_ready,
  input  logic                  c1_ren,
  input  logic                  c1_wen,
  input  logic [ADD_WIDTH-1:0]  c1_rd_address,
  input  logic [ADD_WIDTH-1:0]  c1_wr_address,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  output logic [DATA_WIDTH-1:0] c1_rdata,
  output logic                  c1_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADD_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, DONE} state_t;

  localparam logic [3:0] LAST_WAIT = 4'(MEM_LATENCY - 1);

  state_t                state, state_nxt;
  logic                  grant_id;
  logic                  last_grant;
  logic                  lat_ren, lat_wen;
  logic [ADD_WIDTH-1:0]  lat_rd_addr, lat_wr_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [3:0]            wait_cnt;

  logic req0, req1, any_req, pick;

  assign req0    = c0_ren | c0_wen;
  assign req1    = c1_ren | c1_wen;
  assign any_req = req0 | req1;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = ~last_grant;
    else if (req1)    pick = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (any_req) state_nxt = (pick ? c1_wen : c0_wen) ? WRITE : RD_ISSUE;
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = lat_wr_addr;
        mem_wdata = lat_wdata;
        state_nxt = lat_ren ? RD_ISSUE : DONE;
      end
      RD_ISSUE: begin
        mem_en    = 1'b1;
        mem_addr  = lat_rd_addr;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_cnt == LAST_WAIT) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign c0_ready = (state == DONE) && !grant_id;
  assign c1_ready = (state == DONE) &&  grant_id;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant_id    <= 1'b0;
      last_grant  <= 1'b1;
      lat_ren     <= 1'b0;
      lat_wen     <= 1'b0;
      lat_rd_addr <= '0;
      lat_wr_addr <= '0;
      lat_wdata   <= '0;
      wait_cnt    <= '0;
      c0_rdata    <= '0;
      c1_rdata    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_id    <= pick;
            last_grant  <= pick;
            lat_ren     <= pick ? c1_ren        : c0_ren;
            lat_wen     <= pick ? c1_wen        : c0_wen;
            lat_rd_addr <= pick ? c1_rd_address : c0_rd_address;
            lat_wr_addr <= pick ? c1_wr_address : c0_wr_address;
            lat_wdata   <= pick ? c1_wdata      : c0_wdata;
          end
        end
        RD_ISSUE: wait_cnt <= '0;
        RD_WAIT: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (wait_cnt == LAST_WAIT) begin
            if (grant_id) c1_rdata <= mem_rdata;
            else          c0_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard of expected grants, memory model with fixed read latency.
module tb_mem_port_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int LAT = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          c0_ren, c0_wen, c1_ren, c1_wen;
  logic [AW-1:0] c0_rd_address, c0_wr_address, c1_rd_address, c1_wr_address;
  logic [DW-1:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata;
  logic          c0_ready, c1_ready;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .c0_ren(c0_ren), .c0_wen(c0_wen), .c0_rd_address(c0_rd_address),
    .c0_wr_address(c0_wr_address), .c0_wdata(c0_wdata), .c0_rdata(c0_rdata), .c0_ready(c0_ready),
    .c1_ren(c1_ren), .c1_wen(c1_wen), .c1_rd_address(c1_rd_address),
    .c1_wr_address(c1_wr_address), .c1_wdata(c1_wdata), .c1_rdata(c1_rdata), .c1_ready(c1_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 12'h123) ? 32'hDEADBEEF : {20'hA5A5A, a};
  endfunction

  // Backing memory: data appears on mem_rdata only in the cycle it is due, garbage otherwise.
  logic [DW-1:0] store   [0:(1<<AW)-1] = '{default: '0};
  logic          written [0:(1<<AW)-1] = '{default: 1'b0};
  logic [DW-1:0] pipe_d  [0:LAT-1]     = '{default: '0};
  logic          pipe_v  [0:LAT-1]     = '{default: 1'b0};

  always @(posedge clock) begin
    if (mem_en && mem_we) begin
      store[mem_addr]   <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
    pipe_v[0] <= mem_en && !mem_we;
    pipe_d[0] <= written[mem_addr] ? store[mem_addr] : init_val(mem_addr);
  end

  assign mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hBAD0BAD0;

  typedef struct {
    int            port;
    logic          ren;
    logic          wen;
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp;
  } txn_t;

  txn_t          sb[$];
  txn_t          inj_q[$];
  txn_t          follow[$];
  logic [DW-1:0] shadow [int];
  logic [DW-1:0] last_rd [0:1];
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input int port, input logic ren, input logic wen,
                              input logic [AW-1:0] rd, input logic [AW-1:0] wr,
                              input logic [DW-1:0] wd);
    txn_t t;
    t.port = port; t.ren = ren; t.wen = wen;
    t.rd = rd; t.wr = wr; t.wd = wd; t.exp = '0;
    return t;
  endfunction

  // Pushed in expected grant order; the writeback lands before the fill reads.
  task automatic push(input txn_t t);
    txn_t u;
    u = t;
    if (u.wen) shadow[int'(u.wr)] = u.wd;
    if (u.ren) u.exp = shadow.exists(int'(u.rd)) ? shadow[int'(u.rd)] : init_val(u.rd);
    sb.push_back(u);
  endtask

  task automatic drive(input txn_t t);
    if (t.port == 0) begin
      c0_ren = t.ren; c0_wen = t.wen; c0_rd_address = t.rd; c0_wr_address = t.wr; c0_wdata = t.wd;
    end else begin
      c1_ren = t.ren; c1_wen = t.wen; c1_rd_address = t.rd; c1_wr_address = t.wr; c1_wdata = t.wd;
    end
  endtask

  task automatic drop_port(input int p);
    if (p == 0) begin
      c0_ren = 1'b0; c0_wen = 1'b0;
      c0_rd_address = AW'($urandom); c0_wr_address = AW'($urandom); c0_wdata = $urandom;
    end else begin
      c1_ren = 1'b0; c1_wen = 1'b0;
      c1_rd_address = AW'($urandom); c1_wr_address = AW'($urandom); c1_wdata = $urandom;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mem"}, {18'b0, mem_en, mem_we, mem_addr, mem_wdata}, 64'b0);
    chk({tag, "_rdy"}, {62'b0, c1_ready, c0_ready}, 64'b0);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk_idle("reset");
      chk("reset_rdata", {c0_rdata, c1_rdata}, 64'b0);
    end
    reset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  // Called at the negedge of the cycle in which the first request is driven (cycle 0).
  task automatic serve(input int n, input int inj_at);
    int            j, t0, wc, rdc, rc;
    txn_t          t;
    logic [45:0]   exp_mem;
    logic [DW-1:0] exp_rd, obs_rd, oth_rd;
    j = 0;
    t0 = 0;
    for (int k = 0; k < n; k++) begin
      if (sb.size() == 0) begin
        $display("FAIL scoreboard_empty observed=0 expected=%0d", n - k);
        $fatal(1, "scoreboard underflow");
      end
      t   = sb.pop_front();
      wc  = t.wen ? t0 + 1 : -1;
      rdc = t.ren ? t0 + 1 + (t.wen ? 1 : 0) : -1;
      rc  = t.ren ? rdc + 1 + LAT : t0 + 2;
      while (j < rc) begin
        @(negedge clock);
        j++;
        if (j == wc)       exp_mem = {1'b1, 1'b1, t.wr, t.wd};
        else if (j == rdc) exp_mem = {1'b1, 1'b0, t.rd, {DW{1'b0}}};
        else               exp_mem = '0;
        chk($sformatf("mem_p%0d_c%0d", t.port, j),
            {18'b0, mem_en, mem_we, mem_addr, mem_wdata}, {18'b0, exp_mem});
        chk($sformatf("ready_p%0d_c%0d", t.port, j), {62'b0, c1_ready, c0_ready},
            {62'b0, (j == rc) && (t.port == 1), (j == rc) && (t.port == 0)});
        if (j == inj_at && inj_q.size() > 0) drive(inj_q.pop_front());
      end
      exp_rd = t.ren ? t.exp : last_rd[t.port];
      last_rd[t.port] = exp_rd;
      obs_rd = (t.port == 0) ? c0_rdata : c1_rdata;
      oth_rd = (t.port == 0) ? c1_rdata : c0_rdata;
      chk($sformatf("rdata_p%0d", t.port), {32'b0, obs_rd}, {32'b0, exp_rd});
      chk($sformatf("rdata_other_p%0d", 1 - t.port), {32'b0, oth_rd}, {32'b0, last_rd[1 - t.port]});
      drop_port(t.port);
      if (follow.size() > 0 && follow[0].port == t.port) drive(follow.pop_front());
      t0 = rc + 1;
    end
    @(negedge clock);
    chk_idle("after_serve");
  endtask

  initial begin
    txn_t t0x, t1x;
    reset = 1'b1;
    drive(mk(0, 1'b1, 1'b1, 12'h111, 12'h222, 32'h01010101));
    drive(mk(1, 1'b1, 1'b1, 12'h333, 12'h444, 32'h02020202));
    @(negedge clock);

    // Reset held with both ports requesting, then one quiet idle cycle.
    reset_dut();
    drop_port(0);
    drop_port(1);
    @(negedge clock);
    chk_idle("post_reset_idle");

    // Read-only fill on port 0.
    t0x = mk(0, 1'b1, 1'b0, 12'h123, 12'h000, 32'h0);
    push(t0x); drive(t0x); serve(1, -1);

    // Writeback then fill on port 1.
    t1x = mk(1, 1'b1, 1'b1, 12'h3A5, 12'h0A5, 32'h11112222);
    push(t1x); drive(t1x); serve(1, -1);

    // Writeback and fill to the same address must return the new data.
    t0x = mk(0, 1'b1, 1'b1, 12'h200, 12'h200, 32'hCAFEF00D);
    push(t0x); drive(t0x); serve(1, -1);

    // Write-only leaves port 0's rdata untouched; port 1 then reads it back.
    t0x = mk(0, 1'b0, 1'b1, 12'h000, 12'h3A5, 32'h0BADF00D);
    push(t0x); drive(t0x); serve(1, -1);
    t1x = mk(1, 1'b1, 1'b0, 12'h3A5, 12'h000, 32'h0);
    push(t1x); drive(t1x); serve(1, -1);

    // Simultaneous pairs after reset: port 0 first both times.
    reset_dut();
    for (int p = 0; p < 2; p++) begin
      t0x = mk(0, 1'b1, 1'b0, 12'h010 + 12'(p), 12'h0, 32'h0);
      t1x = mk(1, 1'b1, 1'b0, 12'h020 + 12'(p), 12'h0, 32'h0);
      push(t0x); push(t1x);
      drive(t0x); drive(t1x);
      serve(2, -1);
    end

    // Port 1 requests continuously; port 0 arrives mid-transaction and gets the next grant.
    t1x = mk(1, 1'b1, 1'b1, 12'h123, 12'h123, 32'h55AA55AA);
    t0x = mk(0, 1'b1, 1'b0, 12'h123, 12'h000, 32'h0);
    push(t1x); push(t0x);
    inj_q.push_back(t0x);
    t1x = mk(1, 1'b0, 1'b1, 12'h000, 12'h0C0, 32'h77778888);
    push(t1x);
    follow.push_back(t1x);
    drive(sb[0]);
    serve(3, 2);

    // Reset during RD_WAIT abandons the fill and restores port 0 tie priority.
    reset_dut();
    drive(mk(0, 1'b1, 1'b0, 12'h050, 12'h000, 32'h0));
    @(negedge clock);
    chk("abort_issue", {18'b0, mem_en, mem_we, mem_addr, mem_wdata}, {18'b0, 1'b1, 1'b0, 12'h050, 32'h0});
    @(negedge clock);
    chk_idle("abort_wait");
    reset = 1'b1;
    drop_port(0);
    @(negedge clock);
    chk_idle("abort_reset");
    chk("abort_rdata", {c0_rdata, c1_rdata}, 64'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk_idle($sformatf("abort_after%0d", i));
      chk($sformatf("abort_rdata%0d", i), {c0_rdata, c1_rdata}, 64'b0);
    end
    t0x = mk(0, 1'b1, 1'b0, 12'h0A5, 12'h0, 32'h0);
    t1x = mk(1, 1'b1, 1'b0, 12'h200, 12'h0, 32'h0);
    push(t0x); push(t1x);
    drive(t0x); drive(t1x);
    serve(2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
